// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Receive side of a multiplexed 7-segment display link. Watches the scanned
//   anode/cathode/dp lines, decodes each settled digit back to a hex nibble,
//   rebuilds the 32-bit displayed word and publishes it once the same complete
//   frame has been seen MATCH_FRAMES times in a row.
//
// Parameters
//   SETTLE_CYCLES  anode dwell (clk cycles) before a digit is sampled, 1..255
//   MATCH_FRAMES   consecutive identical frames before publishing, 1..15
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   anode      in   8   digit select, active-low, one-hot-low
//   cathode    in   7   segments {g,f,e,d,c,b,a}, active-low
//   dp         in   1   decimal point, active-low
//   word       out  32  published value, digit i in word[4i+3:4i]
//   dp_mask    out  8   published dp state, bit i set = digit i dp lit
//   word_valid out  1   one-cycle pulse when word/dp_mask update
//   locked     out  1   set once the first word has been published
//   seg_err    out  1   one-cycle pulse on an illegal anode or cathode sample
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MATCH_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        dp,
  output logic [31:0] word,
  output logic [7:0]  dp_mask,
  output logic        word_valid,
  output logic        locked,
  output logic        seg_err
);

  localparam logic [7:0] SETTLE_W = 8'(SETTLE_CYCLES);
  localparam logic [3:0] MATCH_W  = 4'(MATCH_FRAMES);

  // Returns {valid, nibble}; valid=0 for any pattern outside the hex font.
  function automatic logic [4:0] decode7(input logic [6:0] c);
    logic [4:0] r;
    case (c)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // True when exactly one anode line is driven low.
  function automatic logic one_low(input logic [7:0] a);
    logic [7:0] inv;
    inv = ~a;
    return (inv != 8'h00) && ((inv & (inv - 8'd1)) == 8'h00);
  endfunction

  logic [7:0]  anode_q, anode_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sampled_q, sampled_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  dp_shadow_q, dp_shadow_d;
  logic [7:0]  seen_q, seen_d;
  logic [39:0] frame_q, frame_d;
  logic        frame_vld_q, frame_vld_d;
  logic [39:0] last_q, last_d;
  logic [3:0]  match_q, match_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  dp_mask_q, dp_mask_d;
  logic        word_valid_q, word_valid_d;
  logic        locked_q, locked_d;
  logic        seg_err_q, seg_err_d;

  logic        change, sampled_eff, fire, blank, legal, store, complete, publish;
  logic [4:0]  dec;
  logic [7:0]  sel, seen_acc;

  always_comb begin
    anode_d      = anode;
    cnt_d        = cnt_q;
    sampled_d    = sampled_q;
    shadow_d     = shadow_q;
    dp_shadow_d  = dp_shadow_q;
    seen_d       = seen_q;
    frame_d      = frame_q;
    frame_vld_d  = 1'b0;
    last_d       = last_q;
    match_d      = match_q;
    word_d       = word_q;
    dp_mask_d    = dp_mask_q;
    word_valid_d = 1'b0;
    locked_d     = locked_q;
    seg_err_d    = 1'b0;
    publish      = 1'b0;

    // Sample stage: dwell tracking, decode, shadow store, frame completion.
    // A change restarts the dwell at 1, so a sample edge that coincides with
    // an anode change never sees the count at SETTLE_CYCLES for the old digit.
    change      = (anode != anode_q);
    sampled_eff = change ? 1'b0 : sampled_q;
    if (change)              cnt_d = 8'd1;
    else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    fire      = (cnt_d == SETTLE_W) && !sampled_eff;
    sampled_d = sampled_eff | fire;

    dec   = decode7(cathode);
    blank = (anode == 8'hFF);
    legal = one_low(anode);
    sel   = ~anode;
    store = fire && legal && dec[4];
    seg_err_d = fire && !blank && (!legal || !dec[4]);

    for (int i = 0; i < 8; i++) begin
      if (store && sel[i]) begin
        shadow_d[4*i +: 4] = dec[3:0];
        dp_shadow_d[i]     = ~dp;
      end
    end
    seen_acc = seen_q | (store ? sel : 8'h00);
    complete = store && (seen_acc == 8'hFF);
    seen_d   = complete ? 8'h00 : seen_acc;
    if (complete) begin
      frame_d     = {dp_shadow_d, shadow_d};
      frame_vld_d = 1'b1;
    end

    // Match stage: one edge after the completing sample.
    if (frame_vld_q) begin
      if (match_q == 4'd0 || frame_q != last_q) match_d = 4'd1;
      else if (match_q != 4'd15)                match_d = match_q + 4'd1;
      last_d  = frame_q;
      publish = (match_d >= MATCH_W) &&
                (!locked_q || frame_q != {dp_mask_q, word_q});
    end
    if (publish) begin
      word_d       = frame_q[31:0];
      dp_mask_d    = frame_q[39:32];
      word_valid_d = 1'b1;
      locked_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      anode_q      <= 8'hFF;
      cnt_q        <= 8'd0;
      sampled_q    <= 1'b0;
      shadow_q     <= 32'h0;
      dp_shadow_q  <= 8'h00;
      seen_q       <= 8'h00;
      frame_q      <= 40'h0;
      frame_vld_q  <= 1'b0;
      last_q       <= 40'h0;
      match_q      <= 4'd0;
      word_q       <= 32'h0;
      dp_mask_q    <= 8'h00;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      seg_err_q    <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      cnt_q        <= cnt_d;
      sampled_q    <= sampled_d;
      shadow_q     <= shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      seen_q       <= seen_d;
      frame_q      <= frame_d;
      frame_vld_q  <= frame_vld_d;
      last_q       <= last_d;
      match_q      <= match_d;
      word_q       <= word_d;
      dp_mask_q    <= dp_mask_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      seg_err_q    <= seg_err_d;
    end
  end

  assign word       = word_q;
  assign dp_mask    = dp_mask_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign seg_err    = seg_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture (SETTLE_CYCLES=4, MATCH_FRAMES=2).
// Stimulus pushes the expected published word into a queue; a monitor pops
// and compares on every word_valid pulse and counts seg_err pulses.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic [31:0] word;
  logic [7:0]  dp_mask;
  logic        word_valid, locked, seg_err;

  seg7_scan_capture #(.SETTLE_CYCLES(4), .MATCH_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .anode(anode), .cathode(cathode), .dp(dp),
    .word(word), .dp_mask(dp_mask), .word_valid(word_valid),
    .locked(locked), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct { logic [31:0] w; logic [7:0] m; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: scoreboard pop on every published word.
  always @(negedge clk) begin
    exp_t e;
    if (seg_err) errs++;
    if (word_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual word=%h required no pulse", word);
      end else begin
        e = exp_q.pop_front();
        chk("pub_word", 64'(word), 64'(e.w));
        chk("pub_dp_mask", 64'(dp_mask), 64'(e.m));
        chk("pub_locked", 64'(locked), 64'd1);
      end
    end
  end

  task automatic raw(input logic [7:0] a, input logic [6:0] c, input logic d, input int dwell);
    @(negedge clk);
    anode = a; cathode = c; dp = d;
    repeat (dwell) @(posedge clk);
  endtask

  task automatic show(input int dig, input logic [3:0] nib, input logic dpon, input int dwell);
    raw(~(8'h01 << dig), enc[nib], ~dpon, dwell);
  endtask

  // One scan of digits 0..7; short_dig gets a 3-cycle dwell, bad_dig an illegal cathode.
  task automatic frame(input logic [31:0] w, input logic [7:0] m,
                       input int short_dig, input int bad_dig);
    for (int d = 0; d < 8; d++) begin
      if (d == bad_dig) raw(~(8'h01 << d), 7'h7F, 1'b1, 8);
      else              show(d, w[4*d +: 4], m[d], (d == short_dig) ? 3 : 8);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic [7:0] m);
    exp_t e;
    e.w = w; e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_word"}, 64'(word), 64'd0);
    chk({tag, "_dp_mask"}, 64'(dp_mask), 64'd0);
    chk({tag, "_word_valid"}, 64'(word_valid), 64'd0);
    chk({tag, "_locked"}, 64'(locked), 64'd0);
    chk({tag, "_seg_err"}, 64'(seg_err), 64'd0);
  endtask

  initial begin
    int p0, e0;
    rst = 1'b1; anode = 8'hFF; cathode = 7'h7F; dp = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");

    // 1: stable 0x1234ABCD publishes once after the second frame.
    p0 = pulses;
    push(32'h1234ABCD, 8'h00);
    frame(32'h1234ABCD, 8'h00, -1, -1);
    chk("t1_frame1_pulses", 64'(pulses - p0), 64'd0);
    frame(32'h1234ABCD, 8'h00, -1, -1);
    chk("t1_frame2_pulses", 64'(pulses - p0), 64'd1);
    frame(32'h1234ABCD, 8'h00, -1, -1);
    chk("t1_frame3_pulses", 64'(pulses - p0), 64'd1);
    chk("t1_word", 64'(word), 64'h1234ABCD);
    chk("t1_locked", 64'(locked), 64'd1);

    // 2: switch to 0xDEADBEEF with dp on digit 5.
    p0 = pulses;
    push(32'hDEADBEEF, 8'h20);
    frame(32'hDEADBEEF, 8'h20, -1, -1);
    chk("t2_frame1_pulses", 64'(pulses - p0), 64'd0);
    frame(32'hDEADBEEF, 8'h20, -1, -1);
    chk("t2_frame2_pulses", 64'(pulses - p0), 64'd1);
    chk("t2_dp_mask", 64'(dp_mask), 64'h20);

    // 3: short dwell on digit 4 keeps the frame open.
    p0 = pulses;
    frame(32'h55555555, 8'h00, 4, -1);
    frame(32'h55555555, 8'h00, 4, -1);
    chk("t3_short_pulses", 64'(pulses - p0), 64'd0);
    show(4, 4'h5, 1'b0, 4);
    push(32'h55555555, 8'h00);
    frame(32'h55555555, 8'h00, -1, -1);
    chk("t3_complete_pulses", 64'(pulses - p0), 64'd1);

    // 4: illegal cathode and anode samples.
    p0 = pulses; e0 = errs;
    frame(32'h99999999, 8'h00, -1, 3);
    chk("t4_cath_err1", 64'(errs - e0), 64'd1);
    frame(32'h99999999, 8'h00, -1, 3);
    chk("t4_cath_err2", 64'(errs - e0), 64'd2);
    chk("t4_no_pulse", 64'(pulses - p0), 64'd0);
    raw(8'hFC, enc[0], 1'b1, 8);
    chk("t4_anode_err", 64'(errs - e0), 64'd3);
    raw(8'hFF, enc[0], 1'b1, 8);
    chk("t4_blank_no_err", 64'(errs - e0), 64'd3);
    chk("t4_word_kept", 64'(word), 64'h55555555);

    // 6: reset mid-frame after five digits.
    for (int d = 0; d < 5; d++) show(d, 4'hA, 1'b0, 8);
    do_reset();
    chk_zero("t6_reset");
    p0 = pulses;
    push(32'h0F0F3C96, 8'h81);
    frame(32'h0F0F3C96, 8'h81, -1, -1);
    chk("t6_frame1_pulses", 64'(pulses - p0), 64'd0);
    frame(32'h0F0F3C96, 8'h81, -1, -1);
    chk("t6_frame2_pulses", 64'(pulses - p0), 64'd1);

    // 5: alternating frames never publish.
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) frame(32'h11111111, 8'h00, -1, -1);
      else            frame(32'h22222222, 8'h00, -1, -1);
    end
    chk("t5_pulses", 64'(pulses - p0), 64'd0);
    chk("t5_locked", 64'(locked), 64'd0);
    chk("t5_word", 64'(word), 64'd0);

    repeat (4) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
